// File: rtl/cal_edge_delay_ctrl.sv
// Coarse/fine edge-delay controller for the calibration-injection delay chain.
// A trigger after arm waits coarse+1 cycles, then drives a PULSE_LEN-cycle edge with a frozen tap select.
module cal_edge_delay_ctrl #(
  parameter int COARSE_W  = 8,
  parameter int TAP_W     = 4,
  parameter int PULSE_LEN = 4,
  parameter int MISS_W    = 8
) (
  input  logic                CLK,
  input  logic                RST_B,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [COARSE_W-1:0] cfg_coarse,
  input  logic [TAP_W-1:0]    cfg_fine,
  input  logic                arm,
  input  logic                abort,
  input  logic                trig,
  output logic [TAP_W-1:0]    tap_sel,
  output logic                edge_out,
  output logic                busy,
  output logic                done,
  output logic [MISS_W-1:0]   miss_cnt,
  output logic [2:0]          state_dbg
);

  // Handshake: a setting transfers on a rising CLK edge where cfg_valid and cfg_ready
  // are both high and abort is low; cfg_ready is high only in IDLE and cfg_valid is
  // ignored (not queued) elsewhere.

  localparam int PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_COUNT = 3'd2,
    S_FIRE  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [COARSE_W-1:0] coarse_q;
  logic [COARSE_W-1:0] counter;
  logic [PCNT_W-1:0]   pulse_cnt;
  logic                cfg_xfer;
  logic                miss_inc;

  assign state_dbg = state;

  always_comb begin
    next_state = state;
    cfg_xfer   = 1'b0;
    miss_inc   = trig && (state != S_ARMED);
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          cfg_xfer = cfg_valid;
          if (arm) next_state = S_ARMED;
        end
        S_ARMED: begin
          if (trig) next_state = (coarse_q == '0) ? S_FIRE : S_COUNT;
        end
        S_COUNT: begin
          if (counter == COARSE_W'(1)) next_state = S_FIRE;
        end
        S_FIRE: begin
          if (pulse_cnt == '0) next_state = S_DONE;
        end
        S_DONE:  next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Output flops decode the next state so every output is registered.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      edge_out  <= 1'b0;
      done      <= 1'b0;
    end else begin
      cfg_ready <= (next_state == S_IDLE);
      busy      <= (next_state != S_IDLE);
      edge_out  <= (next_state == S_FIRE);
      done      <= (next_state == S_DONE);
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      coarse_q <= '0;
      tap_sel  <= '0;
    end else if (cfg_xfer) begin
      coarse_q <= cfg_coarse;
      tap_sel  <= cfg_fine;
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      counter <= '0;
    end else if (abort) begin
      counter <= '0;
    end else if (state == S_ARMED && trig && coarse_q != '0) begin
      counter <= coarse_q;
    end else if (state == S_COUNT) begin
      counter <= counter - COARSE_W'(1);
    end
  end

  // Pulse length counter loads on FIRE entry and counts down to the last high cycle.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      pulse_cnt <= '0;
    end else if (abort) begin
      pulse_cnt <= '0;
    end else if (next_state == S_FIRE && state != S_FIRE) begin
      pulse_cnt <= PULSE_LAST;
    end else if (state == S_FIRE && pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - PCNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      miss_cnt <= '0;
    end else if (miss_inc && miss_cnt != '1) begin
      miss_cnt <= miss_cnt + MISS_W'(1);
    end
  end

endmodule

// File: tb/tb_cal_edge_delay_ctrl.sv
// Randomised and directed bench for cal_edge_delay_ctrl against a timestamp-based reference model.
// Edges and done pulses are predicted as cycle numbers and checked by an independent monitor.
module tb_cal_edge_delay_ctrl;

  localparam int P = 4;

  logic       CLK = 1'b0;
  logic       RST_B = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_coarse = '0;
  logic [3:0] cfg_fine = '0;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic       trig = 1'b0;
  logic [3:0] tap_sel;
  logic       edge_out;
  logic       busy;
  logic       done;
  logic [7:0] miss_cnt;
  logic [2:0] state_dbg;

  cal_edge_delay_ctrl #(.COARSE_W(8), .TAP_W(4), .PULSE_LEN(P), .MISS_W(8)) dut (
    .CLK(CLK), .RST_B(RST_B), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_coarse(cfg_coarse), .cfg_fine(cfg_fine), .arm(arm), .abort(abort), .trig(trig),
    .tap_sel(tap_sel), .edge_out(edge_out), .busy(busy), .done(done),
    .miss_cnt(miss_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  logic [31:0] cyc = '0;
  always @(posedge CLK) cyc <= cyc + 32'd1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // exp_q entries: {first cycle edge_out is high, first cycle it is low again}
  logic [63:0] exp_q[$];
  logic [31:0] done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flag(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  bit          m_armed = 1'b0;
  logic [31:0] m_idle_at = '0;
  logic [7:0]  m_coarse = '0;
  logic [3:0]  m_tap = '0;
  int          m_miss = 0;

  function automatic bit m_idle(input logic [31:0] k);
    return !m_armed && (k >= m_idle_at);
  endfunction

  task automatic model_update(input logic [31:0] k, input bit cv, input logic [7:0] co,
                              input logic [3:0] fi, input bit ar, input bit ab, input bit tr);
    bit          idle;
    bit          armed;
    logic [31:0] start;
    logic [31:0] stop;
    idle  = m_idle(k);
    armed = m_armed;
    if (tr && !armed && m_miss < 255) m_miss++;
    if (ab) begin
      if (exp_q.size() > 0) begin
        start = exp_q[0][63:32];
        stop  = exp_q[0][31:0];
        if (start > k) begin
          exp_q.delete(0);
          if (done_q.size() > 0) done_q.delete(0);
        end else if (k < stop) begin
          exp_q[0] = {start, k + 32'd1};
          if (done_q.size() > 0) done_q.delete(0);
        end
      end
      m_armed   = 1'b0;
      m_idle_at = k + 32'd1;
    end else begin
      if (idle && cv) begin
        m_coarse = co;
        m_tap    = fi;
      end
      if (idle && ar) m_armed = 1'b1;
      if (armed && tr) begin
        m_armed = 1'b0;
        start   = k + 32'(m_coarse) + 32'd1;
        stop    = start + 32'(P);
        exp_q.push_back({start, stop});
        done_q.push_back(stop);
        m_idle_at = stop + 32'd1;
      end
    end
  endtask

  task automatic check_outputs();
    bit idle;
    idle = m_idle(cyc);
    chk("tap_sel", 32'(tap_sel), 32'(m_tap));
    chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    chk("busy", 32'(busy), 32'(!idle));
    chk("cfg_ready", 32'(cfg_ready), 32'(idle));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit cv, input logic [7:0] co, input logic [3:0] fi,
                      input bit ar, input bit ab, input bit tr);
    @(negedge CLK);
    check_outputs();
    cfg_valid  = cv;
    cfg_coarse = co;
    cfg_fine   = fi;
    arm        = ar;
    abort      = ab;
    trig       = tr;
    model_update(cyc, cv, co, fi, ar, ab, tr);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    cfg_valid = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0;
    #2 RST_B = 1'b0;
    #1;
    chk("rst_edge_out_async", 32'(edge_out), 32'd0);
    chk("rst_busy_async", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    m_armed = 1'b0; m_idle_at = '0; m_coarse = '0; m_tap = '0; m_miss = 0;
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge CLK);
    RST_B = 1'b1;
  endtask

  // ---------------- monitor ----------------
  bit          in_pulse = 1'b0;
  logic [31:0] rise_at = '0;

  always @(posedge CLK) begin
    logic [63:0] e;
    #1;
    if (!RST_B) begin
      in_pulse = 1'b0;
    end else begin
      if (edge_out && !in_pulse) begin
        in_pulse = 1'b1;
        rise_at  = cyc;
      end else if (!edge_out && in_pulse) begin
        in_pulse = 1'b0;
        if (exp_q.size() == 0) begin
          flag("unexpected_edge_rise_cycle", rise_at, 32'hffffffff);
        end else begin
          e = exp_q.pop_front();
          chk("edge_rise_cycle", rise_at, e[63:32]);
          chk("edge_fall_cycle", cyc, e[31:0]);
        end
      end
      if (done) begin
        if (done_q.size() == 0) flag("unexpected_done_cycle", cyc, 32'hffffffff);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      if (exp_q.size() > 0 && !in_pulse && cyc > exp_q[0][31:0]) begin
        e = exp_q.pop_front();
        flag("missing_edge_rise_cycle", 32'hffffffff, e[63:32]);
      end
      if (done_q.size() > 0 && cyc > done_q[0]) begin
        flag("missing_done_cycle", 32'hffffffff, done_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge CLK);
    RST_B = 1'b1;

    // reset release
    @(negedge CLK);
    chk("reset_edge_out", 32'(edge_out), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("reset_miss_cnt", 32'(miss_cnt), 32'd0);
    idle_n(2);

    // coarse=5 fine=9
    step(1'b1, 8'd5, 4'd9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("tap_before_trig", 32'(tap_sel), 32'd9);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle_n(12);

    // coarse=0, cfg+arm same cycle, cfg offered during FIRE
    step(1'b1, 8'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'd7, 4'd12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'd7, 4'd12, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("tap_frozen_in_fire", 32'(tap_sel), 32'd3);
    idle_n(8);

    // missed triggers: three in IDLE, one during COUNT
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      idle_n(1);
    end
    step(1'b1, 8'd20, 4'd5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle_n(4);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle_n(30);
    chk("miss_after_four", 32'(miss_cnt), 32'd4);

    // abort in the second edge_out cycle
    step(1'b1, 8'd2, 4'd6, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle_n(3);
    step(1'b1, 8'd9, 4'd1, 1'b1, 1'b1, 1'b0);
    idle_n(6);
    // abort together with trig while ARMED
    step(1'b0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    idle_n(10);

    // reset during COUNT, then trig without a new arm
    step(1'b1, 8'd10, 4'd8, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle_n(3);
    do_reset();
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle_n(15);

    // reset while edge_out is high
    step(1'b1, 8'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle_n(1);
    do_reset();
    idle_n(6);

    // saturation
    for (int i = 0; i < 300; i++) step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle_n(2);
    chk("miss_saturated", 32'(miss_cnt), 32'd255);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 30, 8'($urandom_range(0, 12)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20);
    end
    idle_n(30);

    chk("edges_outstanding", 32'(exp_q.size()), 32'd0);
    chk("dones_outstanding", 32'(done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
